// File: rtl/rst_seq_pkg.sv
// Shared types and width helpers for the staged reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    S_LOCKWAIT = 2'd0,
    S_HOLD     = 2'd1,
    S_REL      = 2'd2,
    S_RUN      = 2'd3
  } seq_state_e;

  localparam int unsigned LOSS_CNT_W = 8;

  // Bits needed to hold the values 0 .. n_vals-1 (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned n_vals);
    return (n_vals < 2) ? 1 : $clog2(n_vals);
  endfunction

endpackage

// File: rtl/rst_dom_hold.sv
// One domain's reset flop: follows the sequencer, plus a local soft-reset hold.
module rst_dom_hold
  import rst_seq_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic w_pll_clkout1_bufgout,
  input  logic w_rst,
  input  logic seq_rst_c,
  input  logic req,
  output logic dom_rst,
  output logic dom_rst_c
);

  localparam int unsigned HOLD_W = cnt_w(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic              seq_q;
  logic              act_q;
  logic              act_d;
  logic [HOLD_W-1:0] cnt_q;
  logic [HOLD_W-1:0] cnt_d;

  // Local request/hold: honoured only once the sequencer has let this domain go.
  always_comb begin
    act_d = act_q;
    cnt_d = cnt_q;
    if (seq_rst_c) begin
      act_d = 1'b0;
      cnt_d = '0;
    end else if (!seq_q && req) begin
      act_d = 1'b1;
      cnt_d = '0;
    end else if (act_q) begin
      if (cnt_q == HOLD_LAST) begin
        act_d = 1'b0;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + HOLD_W'(1);
      end
    end
  end

  assign dom_rst_c = seq_rst_c | act_d;

  // Register the domain reset and its bookkeeping.
  always_ff @(posedge w_pll_clkout1_bufgout) begin
    if (w_rst) begin
      seq_q   <= 1'b1;
      act_q   <= 1'b0;
      cnt_q   <= '0;
      dom_rst <= 1'b1;
    end else begin
      seq_q   <= seq_rst_c;
      act_q   <= act_d;
      cnt_q   <= cnt_d;
      dom_rst <= dom_rst_c;
    end
  end

endmodule

// File: rtl/rst_seq_ctrl.sv
// PLL-lock qualified, staged multi-domain reset sequencer.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_FILTER = 8,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STAGE_GAP   = 8
) (
  input  logic                   SYSCLK,
  input  logic                   SYSRST,
  input  logic                   PLL_LOCKED,
  input  logic                   SOFT_RST,
  input  logic [NUM_DOMAINS-1:0] DOM_SOFT_RST,
  input  logic                   LOCK_LOSS_CLR,
  output logic [NUM_DOMAINS-1:0] DOM_RST,
  output logic                   ALL_RELEASED,
  output logic                   SEQ_BUSY,
  output logic                   LOCK_LOSS_STICKY,
  output logic [LOSS_CNT_W-1:0]  LOCK_LOSS_CNT
);

  localparam int unsigned FILT_W = cnt_w(LOCK_FILTER);
  localparam int unsigned HOLD_W = cnt_w(HOLD_CYCLES);
  localparam int unsigned GAP_W  = cnt_w(STAGE_GAP);
  localparam int unsigned STG_W  = cnt_w(NUM_DOMAINS);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);
  localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(NUM_DOMAINS - 1);

  if (NUM_DOMAINS < 1 || NUM_DOMAINS > 16) begin : g_bad_num_domains
    $error("rst_seq_ctrl: NUM_DOMAINS must be 1..16");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("rst_seq_ctrl: SYNC_STAGES must be 2..4");
  end
  if (LOCK_FILTER < 1 || HOLD_CYCLES < 1 || STAGE_GAP < 1) begin : g_bad_counts
    $error("rst_seq_ctrl: LOCK_FILTER, HOLD_CYCLES and STAGE_GAP must be >= 1");
  end

  seq_state_e             state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lk_s;
  logic                   loss_c;
  logic [FILT_W-1:0]      filt_q, filt_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [STG_W-1:0]       stage_q, stage_d;
  logic [NUM_DOMAINS-1:0] seq_rst_c;
  logic [NUM_DOMAINS-1:0] dom_rst_c;

  // PLL lock synchroniser.
  always_ff @(posedge SYSCLK) begin
    if (SYSRST) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], PLL_LOCKED};
  end

  assign lk_s   = sync_q[SYNC_STAGES-1];
  assign loss_c = ~lk_s & (state_q != S_LOCKWAIT);

  // Sequencer state and counters.
  always_ff @(posedge SYSCLK) begin
    if (SYSRST) begin
      state_q <= S_LOCKWAIT;
      filt_q  <= '0;
      hold_q  <= '0;
      gap_q   <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      filt_q  <= filt_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      stage_q <= stage_d;
    end
  end

  // Next state: lock loss beats soft reset beats normal progress.
  always_comb begin
    state_d = state_q;
    filt_d  = filt_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    stage_d = stage_q;
    if (loss_c) begin
      state_d = S_LOCKWAIT;
      filt_d  = '0;
      hold_d  = '0;
      gap_d   = '0;
      stage_d = '0;
    end else if (SOFT_RST && state_q != S_LOCKWAIT) begin
      state_d = S_HOLD;
      hold_d  = '0;
      gap_d   = '0;
      stage_d = '0;
    end else begin
      case (state_q)
        S_LOCKWAIT: begin
          if (!lk_s) begin
            filt_d = '0;
          end else if (filt_q == FILT_LAST) begin
            filt_d  = '0;
            hold_d  = '0;
            state_d = S_HOLD;
          end else begin
            filt_d = filt_q + FILT_W'(1);
          end
        end
        S_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            hold_d  = '0;
            gap_d   = '0;
            stage_d = STG_W'(1);
            state_d = (NUM_DOMAINS == 1) ? S_RUN : S_REL;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        S_REL: begin
          if (gap_q == GAP_LAST) begin
            gap_d = '0;
            if (stage_q == STG_LAST) begin
              stage_d = '0;
              state_d = S_RUN;
            end else begin
              stage_d = stage_q + STG_W'(1);
            end
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Domains the sequencer holds after this edge: all until release, then those not yet reached.
  always_comb begin
    seq_rst_c = '0;
    for (int k = 0; k < int'(NUM_DOMAINS); k++) begin
      case (state_d)
        S_LOCKWAIT, S_HOLD: seq_rst_c[k] = 1'b1;
        S_REL:              seq_rst_c[k] = (STG_W'(k) >= stage_d);
        default:            seq_rst_c[k] = 1'b0;
      endcase
    end
  end

  for (genvar k = 0; k < int'(NUM_DOMAINS); k++) begin : g_dom
    rst_dom_hold #(
      .HOLD_CYCLES(HOLD_CYCLES)
    ) u_dom_hold (
      .w_pll_clkout1_bufgout(SYSCLK),
      .w_rst                (SYSRST),
      .seq_rst_c            (seq_rst_c[k]),
      .req                  (DOM_SOFT_RST[k]),
      .dom_rst              (DOM_RST[k]),
      .dom_rst_c            (dom_rst_c[k])
    );
  end

  // Status flags registered alongside the domain resets.
  always_ff @(posedge SYSCLK) begin
    if (SYSRST) begin
      ALL_RELEASED <= 1'b0;
      SEQ_BUSY     <= 1'b1;
    end else begin
      ALL_RELEASED <= ~|dom_rst_c;
      SEQ_BUSY     <= (state_d != S_RUN);
    end
  end

  // Lock-loss statistics; a new loss wins over a same-cycle clear.
  always_ff @(posedge SYSCLK) begin
    if (SYSRST) begin
      LOCK_LOSS_STICKY <= 1'b0;
      LOCK_LOSS_CNT    <= '0;
    end else if (loss_c) begin
      LOCK_LOSS_STICKY <= 1'b1;
      if (LOCK_LOSS_CLR)        LOCK_LOSS_CNT <= LOSS_CNT_W'(1);
      else if (~&LOCK_LOSS_CNT) LOCK_LOSS_CNT <= LOCK_LOSS_CNT + LOSS_CNT_W'(1);
    end else if (LOCK_LOSS_CLR) begin
      LOCK_LOSS_STICKY <= 1'b0;
      LOCK_LOSS_CNT    <= '0;
    end
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: reference model predicts every cycle, monitor compares.
module tb_rst_seq_ctrl;

  localparam int N    = 4;
  localparam int SYNC = 2;
  localparam int FILT = 8;
  localparam int HOLD = 16;
  localparam int GAP  = 8;

  logic         SYSCLK = 1'b0;
  logic         SYSRST;
  logic         PLL_LOCKED;
  logic         SOFT_RST;
  logic [N-1:0] DOM_SOFT_RST;
  logic         LOCK_LOSS_CLR;
  logic [N-1:0] DOM_RST;
  logic         ALL_RELEASED;
  logic         SEQ_BUSY;
  logic         LOCK_LOSS_STICKY;
  logic [7:0]   LOCK_LOSS_CNT;

  always #5 SYSCLK = ~SYSCLK;

  rst_seq_ctrl #(
    .NUM_DOMAINS(N), .SYNC_STAGES(SYNC), .LOCK_FILTER(FILT),
    .HOLD_CYCLES(HOLD), .STAGE_GAP(GAP)
  ) dut (
    .SYSCLK(SYSCLK), .SYSRST(SYSRST), .PLL_LOCKED(PLL_LOCKED),
    .SOFT_RST(SOFT_RST), .DOM_SOFT_RST(DOM_SOFT_RST), .LOCK_LOSS_CLR(LOCK_LOSS_CLR),
    .DOM_RST(DOM_RST), .ALL_RELEASED(ALL_RELEASED), .SEQ_BUSY(SEQ_BUSY),
    .LOCK_LOSS_STICKY(LOCK_LOSS_STICKY), .LOCK_LOSS_CNT(LOCK_LOSS_CNT)
  );

  typedef struct packed {
    logic [N-1:0] dom;
    logic         all_rel;
    logic         busy;
    logic         sticky;
    logic [7:0]   cnt;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: phase 0 wait-lock, 1 hold, 2 staged release, 3 run.
  int m_phase, m_qual, m_held, m_rel_t, m_cnt;
  bit m_sticky;
  bit m_act[N];
  int m_quiet[N];
  bit m_pipe[$];

  function automatic bit seq_held(int k);
    if (m_phase < 2) return 1'b1;
    if (m_phase == 2) return (m_rel_t < GAP * k);
    return 1'b0;
  endfunction

  function automatic void model_step();
    obs_t e;
    bit   prev[N];
    bit   lk, loss, abort;
    if (SYSRST) begin
      m_phase = 0; m_qual = 0; m_held = 0; m_rel_t = 0;
      m_sticky = 1'b0; m_cnt = 0;
      for (int k = 0; k < N; k++) begin m_act[k] = 1'b0; m_quiet[k] = 0; end
      m_pipe.delete();
      for (int i = 0; i < SYNC; i++) m_pipe.push_back(1'b0);
    end else begin
      lk = m_pipe.pop_front();
      m_pipe.push_back(PLL_LOCKED);
      for (int k = 0; k < N; k++) prev[k] = seq_held(k);
      loss = !lk && (m_phase != 0);
      if (loss) begin
        m_sticky = 1'b1;
        m_cnt = LOCK_LOSS_CLR ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
      end else if (LOCK_LOSS_CLR) begin
        m_sticky = 1'b0;
        m_cnt = 0;
      end
      abort = 1'b0;
      if (loss) begin
        m_phase = 0; m_qual = 0; abort = 1'b1;
      end else if (SOFT_RST && m_phase != 0) begin
        m_phase = 1; m_held = 0; abort = 1'b1;
      end else begin
        case (m_phase)
          0: begin
            m_qual = lk ? m_qual + 1 : 0;
            if (m_qual == FILT) begin m_phase = 1; m_held = 0; m_qual = 0; end
          end
          1: begin
            m_held++;
            if (m_held == HOLD) begin m_phase = (N == 1) ? 3 : 2; m_rel_t = 0; end
          end
          2: begin
            m_rel_t++;
            if (m_rel_t == GAP * (N - 1)) m_phase = 3;
          end
          default: ;
        endcase
      end
      for (int k = 0; k < N; k++) begin
        if (abort || seq_held(k)) begin
          m_act[k] = 1'b0;
        end else if (!prev[k] && DOM_SOFT_RST[k]) begin
          m_act[k] = 1'b1; m_quiet[k] = 0;
        end else if (m_act[k]) begin
          m_quiet[k]++;
          if (m_quiet[k] == HOLD) m_act[k] = 1'b0;
        end
      end
    end
    for (int k = 0; k < N; k++) e.dom[k] = seq_held(k) | m_act[k];
    e.all_rel = (e.dom == '0);
    e.busy    = (m_phase != 3);
    e.sticky  = m_sticky;
    e.cnt     = 8'(m_cnt);
    exp_q.push_back(e);
  endfunction

  // Monitor: compare DUT outputs with the model prediction every cycle.
  obs_t mon_e, mon_o;
  initial begin
    forever begin
      @(negedge SYSCLK);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_o = {DOM_RST, ALL_RELEASED, SEQ_BUSY, LOCK_LOSS_STICKY, LOCK_LOSS_CNT};
        checks++;
        if (mon_o !== mon_e) begin
          errors++;
          if (errors <= 20)
            $display("FAIL cycle_cmp t=%0t got dom=%h rel=%b busy=%b sticky=%b cnt=%0d, expected dom=%h rel=%b busy=%b sticky=%b cnt=%0d",
                     $time, mon_o.dom, mon_o.all_rel, mon_o.busy, mon_o.sticky, mon_o.cnt,
                     mon_e.dom, mon_e.all_rel, mon_e.busy, mon_e.sticky, mon_e.cnt);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge SYSCLK);
    model_step();
    #1;
  endtask

  // Step until DOM_RST[0] is low, counting edges; a spent budget counts as a failure.
  task automatic steps_until_dom0_low(input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (DOM_RST[0] !== 1'b0 && n < budget);
    if (DOM_RST[0] !== 1'b0) chk("dom0_release_timeout", n, -1);
  endtask

  task automatic lock_blip();
    PLL_LOCKED = 1'b0;
    step();
    PLL_LOCKED = 1'b1;
  endtask

  int n;
  bit seen_f;

  initial begin
    SYSRST = 1'b1; PLL_LOCKED = 1'b1; SOFT_RST = 1'b0;
    DOM_SOFT_RST = '0; LOCK_LOSS_CLR = 1'b0;
    repeat (3) step();
    chk("reset_dom", int'(DOM_RST), 15);
    chk("reset_busy", int'(SEQ_BUSY), 1);

    // Power-up release schedule.
    SYSRST = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      step();
      if (c == 25) chk("pwr_dom_c25", int'(DOM_RST), 15);
      if (c == 26) chk("pwr_dom_c26", int'(DOM_RST), 14);
      if (c == 33) chk("pwr_dom_c33", int'(DOM_RST), 14);
      if (c == 34) chk("pwr_dom_c34", int'(DOM_RST), 12);
      if (c == 42) chk("pwr_dom_c42", int'(DOM_RST), 8);
      if (c == 49) chk("pwr_allrel_c49", int'(ALL_RELEASED), 0);
      if (c == 50) begin
        chk("pwr_dom_c50", int'(DOM_RST), 0);
        chk("pwr_allrel_c50", int'(ALL_RELEASED), 1);
        chk("pwr_busy_c50", int'(SEQ_BUSY), 0);
      end
    end
    repeat (5) step();

    // Single-cycle lock loss in S_RUN.
    lock_blip();
    step();
    chk("loss_dom_before", int'(DOM_RST), 0);
    step();
    chk("loss_dom_set", int'(DOM_RST), 15);
    chk("loss_sticky", int'(LOCK_LOSS_STICKY), 1);
    chk("loss_cnt", int'(LOCK_LOSS_CNT), 1);
    repeat (60) step();
    chk("loss_rerelease", int'(ALL_RELEASED), 1);

    // Lone clear.
    LOCK_LOSS_CLR = 1'b1; step(); LOCK_LOSS_CLR = 1'b0;
    chk("clr_sticky", int'(LOCK_LOSS_STICKY), 0);
    chk("clr_cnt", int'(LOCK_LOSS_CNT), 0);

    // Global soft reset for 10 cycles.
    SOFT_RST = 1'b1;
    seen_f = 1'b1;
    repeat (10) begin
      step();
      if (DOM_RST !== 4'hF) seen_f = 1'b0;
    end
    chk("soft_dom_held", int'(seen_f), 1);
    SOFT_RST = 1'b0;
    steps_until_dom0_low(100, n);
    chk("soft_release_delay", n, HOLD);
    chk("soft_sticky", int'(LOCK_LOSS_STICKY), 0);
    repeat (30) step();

    // Per-domain soft reset on domain 2.
    DOM_SOFT_RST = 4'b0100;
    seen_f = 1'b1;
    repeat (5) begin
      step();
      if (DOM_RST !== 4'b0100 || ALL_RELEASED !== 1'b0) seen_f = 1'b0;
    end
    chk("dsoft_only_dom2", int'(seen_f), 1);
    DOM_SOFT_RST = '0;
    n = 0;
    do begin step(); n++; end while (DOM_RST !== 4'b0000 && n < 100);
    chk("dsoft_hold_len", n, HOLD);

    // Lock glitch during S_LOCKWAIT at filter count 5.
    SYSRST = 1'b1; repeat (2) step(); SYSRST = 1'b0;
    repeat (7) step();
    PLL_LOCKED = 1'b0; repeat (3) step(); PLL_LOCKED = 1'b1;
    steps_until_dom0_low(100, n);
    chk("glitch_release_delay", n, 26);
    chk("glitch_cnt", int'(LOCK_LOSS_CNT), 0);
    repeat (30) step();

    // Clear coinciding with a new loss, starting from CNT=4.
    repeat (4) begin lock_blip(); repeat (20) step(); end
    chk("cnt_four", int'(LOCK_LOSS_CNT), 4);
    lock_blip();
    step();
    LOCK_LOSS_CLR = 1'b1; step(); LOCK_LOSS_CLR = 1'b0;
    chk("clr_vs_loss_sticky", int'(LOCK_LOSS_STICKY), 1);
    chk("clr_vs_loss_cnt", int'(LOCK_LOSS_CNT), 1);

    // Counter saturation after 300 losses.
    repeat (300) begin lock_blip(); repeat (14) step(); end
    chk("sat_cnt", int'(LOCK_LOSS_CNT), 255);
    chk("sat_sticky", int'(LOCK_LOSS_STICKY), 1);

    // Randomised traffic.
    for (int c = 0; c < 4000; c++) begin
      PLL_LOCKED    = ($urandom_range(0, 999) < 5) ? 1'b0 : 1'b1;
      SYSRST        = ($urandom_range(0, 999) < 2) ? 1'b1 : 1'b0;
      LOCK_LOSS_CLR = ($urandom_range(0, 99) < 1) ? 1'b1 : 1'b0;
      if (SOFT_RST) SOFT_RST = ($urandom_range(0, 99) < 20) ? 1'b0 : 1'b1;
      else          SOFT_RST = ($urandom_range(0, 999) < 5) ? 1'b1 : 1'b0;
      for (int k = 0; k < N; k++) begin
        if (DOM_SOFT_RST[k]) DOM_SOFT_RST[k] = ($urandom_range(0, 99) < 30) ? 1'b0 : 1'b1;
        else                 DOM_SOFT_RST[k] = ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0;
      end
      step();
    end
    SYSRST = 1'b0; SOFT_RST = 1'b0; DOM_SOFT_RST = '0; LOCK_LOSS_CLR = 1'b0; PLL_LOCKED = 1'b1;
    repeat (3) step();
    repeat (2) @(negedge SYSCLK);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
- Parametrised reset sequencer in the SYSCLK domain; the successor to the fixed 4-flop release chains in the clock/reset generator.
- Qualifies the PLL lock with a synchroniser and a stability filter, then releases NUM_DOMAINS reset outputs in staged order (domain 0 first).
- Adds per-domain soft reset, lock-loss detection with a sticky flag and counter, and a global soft-reset restart.
- Sits directly after the PLL/BUFG stage; its outputs feed every downstream block reset.

Parameters:
- NUM_DOMAINS, 4, number of reset outputs (1..16)
- SYNC_STAGES, 2, PLL_LOCKED synchroniser depth (2..4)
- LOCK_FILTER, 8, consecutive synchronised-locked cycles required before the hold phase starts (>=1)
- HOLD_CYCLES, 16, minimum reset hold after qualification or after any soft-reset request drops (>=1)
- STAGE_GAP, 8, cycles between release of domain k and domain k+1 (>=1; unused when NUM_DOMAINS=1)

Ports:
- SYSCLK  in  1  system clock
- SYSRST  in  1  synchronous, active-high reset
- PLL_LOCKED  in  1  asynchronous PLL lock status
- SOFT_RST  in  1  global soft reset, level, synchronous to SYSCLK
- DOM_SOFT_RST  in  NUM_DOMAINS  per-domain soft reset requests, level
- LOCK_LOSS_CLR  in  1  single-cycle pulse; clears LOCK_LOSS_STICKY and LOCK_LOSS_CNT
- DOM_RST  out  NUM_DOMAINS  active-high domain resets, registered
- ALL_RELEASED  out  1  high only when every DOM_RST bit is 0
- SEQ_BUSY  out  1  high in every state except S_RUN
- LOCK_LOSS_STICKY  out  1  set on lock loss
- LOCK_LOSS_CNT  out  8  saturating count of lock-loss events

Behaviour:
- One clock (SYSCLK); reset is synchronous and active-high (SYSRST).
- Values while SYSRST is high:
  - DOM_RST all 1; ALL_RELEASED 0; SEQ_BUSY 1.
  - LOCK_LOSS_STICKY 0; LOCK_LOSS_CNT 0.
  - Synchroniser flops 0; state S_LOCKWAIT; all counters 0.
- Synchroniser: lk_s is PLL_LOCKED delayed by SYNC_STAGES flops.
- S_LOCKWAIT:
  - Filter counter increments while lk_s=1 and clears when lk_s=0.
  - When the count reaches LOCK_FILTER, go to S_HOLD.
- S_HOLD: counts HOLD_CYCLES, then goes to S_REL.
- S_REL:
  - DOM_RST[0] clears on entry.
  - DOM_RST[k] clears STAGE_GAP*k cycles after DOM_RST[0].
  - After DOM_RST[N-1] clears, go to S_RUN.
- Release timing, with PLL_LOCKED high throughout and cycle 1 = first edge sampling SYSRST low:
  - DOM_RST[0] falls at edge SYNC_STAGES+LOCK_FILTER+HOLD_CYCLES.
  - DOM_RST[k] falls STAGE_GAP*k edges after DOM_RST[0].
  - ALL_RELEASED rises on the same edge DOM_RST[N-1] falls.
- Lock loss (lk_s=0 while in S_HOLD, S_REL or S_RUN):
  - All DOM_RST set on the next edge.
  - Go to S_LOCKWAIT with the filter cleared.
  - LOCK_LOSS_STICKY set.
  - LOCK_LOSS_CNT increments, saturating at 255.
  - lk_s=0 in S_LOCKWAIT is not counted as a loss.
- SOFT_RST=1 in any state after S_LOCKWAIT:
  - All DOM_RST set on the next edge; go to S_HOLD.
  - The hold counter stays cleared while SOFT_RST is high.
  - Once SOFT_RST drops: HOLD_CYCLES, then the staged release.
  - Not a lock loss; sticky flag and counter are unaffected.
- DOM_SOFT_RST[k]:
  - Honoured in S_RUN, and in S_REL for domains already released.
  - DOM_RST[k] set on the next edge and held while the request is high, then for HOLD_CYCLES more cycles.
  - Each domain has its own counter; other domains are unaffected.
  - Ignored while DOM_RST[k] is still held by the sequence.
  - A request that re-asserts during the hold count restarts the count when it drops.
- Priority on the same edge: SYSRST > lock loss > SOFT_RST > DOM_SOFT_RST.
  - A lock loss or SOFT_RST aborts all per-domain counters.
- LOCK_LOSS_CLR on the same edge as a new loss: the new loss wins (STICKY=1, CNT=1).
- SOFT_RST held during S_LOCKWAIT:
  - No effect while in S_LOCKWAIT; qualification proceeds normally.
  - On entry to S_HOLD, the hold count stays cleared until SOFT_RST drops.
- Counter widths are sized by $clog2 of the respective maximum.
- Parameter range violations trigger an elaboration-time $error.

Decomposition:
- Package rst_seq_pkg holds:
  - state enum: S_LOCKWAIT, S_HOLD, S_REL, S_RUN
  - LOSS_CNT_W=8
  - width helper functions for the counters
- One sub-module, rst_dom_hold: per-domain request, hold counter and release flop, instantiated NUM_DOMAINS times via generate.
- The top level holds the synchroniser, filter, FSM and loss-statistics logic.

Test Plan (defaults: N=4, SYNC=2, FILTER=8, HOLD=16, GAP=8):
- Power-up: PLL_LOCKED high, SYSRST released at cycle 0 -> DOM_RST[0..3] fall at cycles 26/34/42/50; ALL_RELEASED rises at 50; SEQ_BUSY falls at 50.
- Lock glitch: PLL_LOCKED low for 3 cycles during S_LOCKWAIT at filter count 5 -> filter restarts; DOM_RST[0] falls 26 cycles after the glitch ends (8+16 after lk_s returns); LOCK_LOSS_CNT stays 0.
- Lock loss in S_RUN: PLL_LOCKED low for 1 cycle -> DOM_RST=4'hF two edges after the drop; STICKY=1; CNT=1; full release sequence repeats. 300 such losses -> CNT=255.
- SOFT_RST held for 10 cycles in S_RUN -> DOM_RST=4'hF for the whole pulse; DOM_RST[0] falls 16 cycles after the drop, then 8-cycle stagger; STICKY stays 0.
- DOM_SOFT_RST[2] high for 5 cycles in S_RUN -> only DOM_RST[2] asserts, for 5+16 cycles; ALL_RELEASED low for that window.
- LOCK_LOSS_CLR on the same edge as a lock loss, with CNT=4 -> STICKY=1, CNT=1. A lone clear -> STICKY=0, CNT=0.
